// File: rtl/gnrl_pipe_skid.sv
// Two-entry valid/ready pipeline stage (main + skid register) with fully registered
// o_vld, i_rdy and o_dat, so chained stages share no combinational path.
module gnrl_pipe_skid #(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          i_vld,
   output logic          i_rdy,
   input  logic [DW-1:0] i_dat,
   output logic          o_vld,
   input  logic          o_rdy,
   output logic [DW-1:0] o_dat,
   output logic [1:0]    count
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t        state;
   logic [DW-1:0] main_dat;
   logic [DW-1:0] skid_dat;
   logic          push;
   logic          pop;

   // Handshake: a beat moves on a rising edge only when valid and ready are both
   // high at that edge; a producer whose valid is refused keeps its payload.
   assign push = i_vld & i_rdy;
   assign pop  = o_vld & o_rdy;

   // Every output is a pure decode of flops.
   assign o_vld = (state != EMPTY);
   assign i_rdy = (state != FULL);
   assign o_dat = main_dat;
   assign count = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= EMPTY;
         main_dat <= '0;
         skid_dat <= '0;
      end else begin
         unique case (state)
            EMPTY: begin
               if (push) begin
                  main_dat <= i_dat;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               if (push && pop) begin
                  main_dat <= i_dat;
               end else if (push) begin
                  skid_dat <= i_dat;
                  state    <= FULL;
               end else if (pop) begin
                  state    <= EMPTY;
               end
            end
            FULL: begin
               // i_rdy is low here, so only a pop can move the stage.
               if (pop) begin
                  main_dat <= skid_dat;
                  state    <= BUSY;
               end
            end
            default: state <= EMPTY;
         endcase
         // Flush wins over any transition; data regs are left as don't-care.
         if (flush) state <= EMPTY;
      end
   end

endmodule

// File: tb/tb_gnrl_pipe_skid.sv
// Randomized self-checking bench for gnrl_pipe_skid against a queue-based FIFO model
// of depth 2.
module tb_gnrl_pipe_skid;

   localparam int DW = 32;

   logic          clk;
   logic          rst_n;
   logic          flush;
   logic          i_vld;
   logic          i_rdy;
   logic [DW-1:0] i_dat;
   logic          o_vld;
   logic          o_rdy;
   logic [DW-1:0] o_dat;
   logic [1:0]    count;

   int            n_checks;
   int            n_fail;
   logic [DW-1:0] exp_q[$];
   logic          prev_stall;
   logic [DW-1:0] prev_dat;
   bit            seen_c;

   gnrl_pipe_skid #(.DW(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .i_vld (i_vld),
      .i_rdy (i_rdy),
      .i_dat (i_dat),
      .o_vld (o_vld),
      .o_rdy (o_rdy),
      .o_dat (o_dat),
      .count (count)
   );

   // clock/reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Compare outputs against the model (called at a negedge).
   task automatic check_model();
      check("count", DW'(count), DW'(exp_q.size()));
      check("o_vld", DW'(o_vld), DW'(exp_q.size() > 0));
      check("i_rdy", DW'(i_rdy), DW'(exp_q.size() < 2));
      if (exp_q.size() > 0) check("o_dat", o_dat, exp_q[0]);
   endtask

   // driver: one clock cycle with the given inputs; model updated at the edge.
   task automatic step(input logic vld, input logic [DW-1:0] dat, input logic ordy,
                       input logic fl);
      bit do_push;
      bit do_pop;
      i_vld = vld;
      i_dat = dat;
      o_rdy = ordy;
      flush = fl;
      check_model();
      if (prev_stall) check("stall_hold", o_dat, prev_dat);
      do_push    = vld && (exp_q.size() < 2);
      do_pop     = ordy && (exp_q.size() > 0);
      prev_stall = (exp_q.size() > 0) && !ordy && !fl;
      prev_dat   = o_dat;
      if (do_pop && o_dat == 32'hC) seen_c = 1'b1;
      @(posedge clk);
      if (do_pop) void'(exp_q.pop_front());
      if (fl) exp_q.delete();
      else if (do_push) exp_q.push_back(dat);
      @(negedge clk);
   endtask

   initial begin
      int            pushed;
      int            cycles;
      logic [DW-1:0] next_val;
      n_checks   = 0;
      n_fail     = 0;
      prev_stall = 1'b0;
      prev_dat   = '0;
      seen_c     = 1'b0;
      rst_n = 1'b0;
      flush = 1'b0;
      i_vld = 1'b0;
      i_dat = '0;
      o_rdy = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_o_vld", DW'(o_vld), '0);
      check("rst_count", DW'(count), '0);
      check("rst_o_dat", o_dat, '0);
      check("rst_i_rdy", DW'(i_rdy), 1);
      rst_n = 1'b1;
      @(negedge clk);

      // Back-to-back pushes with o_rdy=1: pass-through with one-cycle latency.
      for (int k = 1; k <= 8; k++) step(1'b1, DW'(k), 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      check("b2b_drained", DW'(count), '0);

      // Fill under backpressure, offer 0xC while full, then drain in order.
      step(1'b1, 32'hA, 1'b0, 1'b0);
      step(1'b1, 32'hB, 1'b0, 1'b0);
      check("full_count", DW'(count), 2);
      check("full_i_rdy", DW'(i_rdy), 0);
      step(1'b1, 32'hC, 1'b0, 1'b0);
      check("full_hold", o_dat, 32'hA);
      for (int k = 0; k < 5; k++) step(1'b1, 32'hC, 1'b1, 1'b0);
      i_vld = 1'b0;
      for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b1, 1'b0);
      check("drain_empty", DW'(count), '0);

      // Flush while FULL with a simultaneous push of 0xC.
      seen_c = 1'b0;
      step(1'b1, 32'hA, 1'b0, 1'b0);
      step(1'b1, 32'hB, 1'b0, 1'b0);
      step(1'b1, 32'hC, 1'b0, 1'b1);
      check("flush_o_vld", DW'(o_vld), 0);
      check("flush_count", DW'(count), 0);
      check("flush_i_rdy", DW'(i_rdy), 1);
      for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b1, 1'b0);
      check("flush_no_c", DW'(seen_c), 0);

      // BUSY with simultaneous push and pop.
      step(1'b1, 32'h5, 1'b0, 1'b0);
      step(1'b1, 32'h6, 1'b1, 1'b0);
      check("pp_count", DW'(count), 1);
      check("pp_o_dat", o_dat, 32'h6);
      step(1'b0, '0, 1'b1, 1'b0);

      // Random traffic: 1000 incrementing beats, scoreboard order.
      pushed   = 0;
      cycles   = 0;
      next_val = 32'h100;
      while (pushed < 1000 && cycles < 20000) begin
         logic v;
         logic r;
         v = 1'($urandom_range(0, 99) < 70);
         r = 1'($urandom_range(0, 99) < 60);
         if (v && exp_q.size() < 2) begin
            step(v, next_val, r, 1'b0);
            next_val++;
            pushed++;
         end else begin
            step(v, next_val, r, 1'b0);
         end
         cycles++;
      end
      check("rand_budget", DW'(pushed), 1000);
      for (int k = 0; k < 4; k++) step(1'b0, '0, 1'b1, 1'b0);
      check("rand_drained", DW'(count), '0);

      // Asynchronous reset in the middle of a cycle with the stage FULL.
      step(1'b1, 32'h11, 1'b0, 1'b0);
      step(1'b1, 32'h22, 1'b0, 1'b0);
      check("pre_rst_count", DW'(count), 2);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_o_vld", DW'(o_vld), 0);
      check("arst_count", DW'(count), 0);
      check("arst_o_dat", o_dat, '0);
      exp_q.delete();
      prev_stall = 1'b0;
      i_vld = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_i_rdy", DW'(i_rdy), 1);
      step(1'b1, 32'h33, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
